// File: rtl/tt_um_torstencc_pipeline_cleaner.sv
// Three-stage sample cleaner: capture, clamp to [CLAMP_LO, CLAMP_HI], 3-tap median de-spike.
// Optional feature: define MEDIAN_BYPASS_EN to let uio_in[2] route the clamped sample straight to the output.
module tt_um_torstencc_pipeline_cleaner #(
  parameter logic [7:0] CLAMP_LO = 8'h10,
  parameter logic [7:0] CLAMP_HI = 8'hEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  function automatic logic [7:0] clamp8(input logic [7:0] v);
    logic [7:0] r;
    if (v < CLAMP_LO) begin
      r = CLAMP_LO;
    end else if (v > CLAMP_HI) begin
      r = CLAMP_HI;
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] mid;
    lo  = (a < b) ? a : b;
    hi  = (a < b) ? b : a;
    mid = (hi < c) ? hi : c;
    return (lo > mid) ? lo : mid;
  endfunction

  logic       s1_valid_q, s1_valid_d;
  logic [7:0] s1_data_q, s1_data_d;
  logic       s2_valid_q, s2_valid_d;
  logic [7:0] s2_data_q, s2_data_d;
  logic       s2_clamped_q, s2_clamped_d;
  logic [7:0] h0_q, h0_d;
  logic [7:0] h1_q, h1_d;
  logic [1:0] fill_q, fill_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       clamp_seen_q, clamp_seen_d;
  logic       last_clamped_q, last_clamped_d;

  logic       in_valid_s;
  logic       flush_s;
  logic [7:0] clamp_s;
  logic [7:0] h0_eff_s;
  logic [7:0] h1_eff_s;
  logic [7:0] med_s;
  logic [7:0] s3_res_s;
  logic       unused_s;

  assign in_valid_s = uio_in[0];
  assign flush_s    = uio_in[1];
  assign clamp_s    = clamp8(s1_data_q);

  // An unfilled history is padded with the incoming sample so the first two outputs pass through.
  assign h0_eff_s = (fill_q == 2'd0) ? s2_data_q : h0_q;
  assign h1_eff_s = (fill_q == 2'd2) ? h1_q : s2_data_q;
  assign med_s    = med3(s2_data_q, h0_eff_s, h1_eff_s);

`ifdef MEDIAN_BYPASS_EN
  assign s3_res_s = uio_in[2] ? s2_data_q : med_s;
  assign unused_s = &{1'b0, uio_in[7:3]};
`else
  assign s3_res_s = med_s;
  assign unused_s = &{1'b0, uio_in[7:2]};
`endif

  // Next-state for every pipeline register; ena=0 holds everything, flush beats new input.
  always_comb begin
    s1_valid_d     = s1_valid_q;
    s1_data_d      = s1_data_q;
    s2_valid_d     = s2_valid_q;
    s2_data_d      = s2_data_q;
    s2_clamped_d   = s2_clamped_q;
    h0_d           = h0_q;
    h1_d           = h1_q;
    fill_d         = fill_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    clamp_seen_d   = clamp_seen_q;
    last_clamped_d = last_clamped_q;
    if (ena) begin
      if (flush_s) begin
        s1_valid_d     = 1'b0;
        s1_data_d      = 8'h00;
        s2_valid_d     = 1'b0;
        s2_data_d      = 8'h00;
        s2_clamped_d   = 1'b0;
        h0_d           = 8'h00;
        h1_d           = 8'h00;
        fill_d         = 2'd0;
        out_data_d     = 8'h00;
        out_valid_d    = 1'b0;
        clamp_seen_d   = 1'b0;
        last_clamped_d = 1'b0;
      end else begin
        s1_valid_d = in_valid_s;
        if (in_valid_s) begin
          s1_data_d = ui_in;
        end else begin
          s1_data_d = s1_data_q;
        end
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_data_d    = clamp_s;
          s2_clamped_d = (clamp_s != s1_data_q);
        end else begin
          s2_data_d    = s2_data_q;
          s2_clamped_d = s2_clamped_q;
        end
        out_valid_d = s2_valid_q;
        if (s2_valid_q) begin
          out_data_d     = s3_res_s;
          h1_d           = h0_eff_s;
          h0_d           = s2_data_q;
          fill_d         = (fill_q == 2'd2) ? 2'd2 : fill_q + 2'd1;
          last_clamped_d = s2_clamped_q;
          clamp_seen_d   = clamp_seen_q | s2_clamped_q;
        end else begin
          out_data_d     = out_data_q;
          h1_d           = h1_q;
          h0_d           = h0_q;
          fill_d         = fill_q;
          last_clamped_d = last_clamped_q;
          clamp_seen_d   = clamp_seen_q;
        end
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Pipeline state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q     <= 1'b0;
      s1_data_q      <= 8'h00;
      s2_valid_q     <= 1'b0;
      s2_data_q      <= 8'h00;
      s2_clamped_q   <= 1'b0;
      h0_q           <= 8'h00;
      h1_q           <= 8'h00;
      fill_q         <= 2'd0;
      out_data_q     <= 8'h00;
      out_valid_q    <= 1'b0;
      clamp_seen_q   <= 1'b0;
      last_clamped_q <= 1'b0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_data_q      <= s1_data_d;
      s2_valid_q     <= s2_valid_d;
      s2_data_q      <= s2_data_d;
      s2_clamped_q   <= s2_clamped_d;
      h0_q           <= h0_d;
      h1_q           <= h1_d;
      fill_q         <= fill_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      clamp_seen_q   <= clamp_seen_d;
      last_clamped_q <= last_clamped_d;
    end
  end

  assign uo_out  = out_data_q;
  assign uio_out = {last_clamped_q, clamp_seen_q, s1_valid_q | s2_valid_q, out_valid_q & ena, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_torstencc_pipeline_cleaner.sv
// Bench for the pipeline cleaner: vector table, directed corner sequences and a random stream vs. a queue model.
module tb_tt_um_torstencc_pipeline_cleaner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  tt_um_torstencc_pipeline_cleaner dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: accepted samples wait in a queue until two more enabled edges pass.
  typedef struct {
    logic [7:0] val;
    int         due;
  } pend_t;

  pend_t      pq[$];
  logic [7:0] hist[$];
  int         k = 0;
  logic [7:0] m_out = 8'h00;
  logic       m_ov = 1'b0;
  logic       m_seen = 1'b0;
  logic       m_last = 1'b0;

  function automatic logic [7:0] ref_clamp(input logic [7:0] v);
    int x;
    x = v;
    if (x < 16) x = 16;
    if (x > 239) x = 239;
    return 8'(x);
  endfunction

  function automatic logic [7:0] ref_median(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    int mx;
    int mn;
    mx = a; mn = a;
    if (b > mx) mx = b;
    if (c > mx) mx = c;
    if (b < mn) mn = b;
    if (c < mn) mn = c;
    return 8'(int'(a) + int'(b) + int'(c) - mx - mn);
  endfunction

  task automatic model_clear();
    pq.delete();
    hist.delete();
    m_out  = 8'h00;
    m_ov   = 1'b0;
    m_seen = 1'b0;
    m_last = 1'b0;
  endtask

  task automatic step(input logic e, input logic v, input logic f, input logic b, input logic [7:0] d);
    pend_t      p;
    logic [7:0] c;
    logic [4:0] junk;
    junk   = 5'($urandom);
    ena    = e;
    ui_in  = d;
    uio_in = {junk, b, f, v};
    @(posedge clk);
    if (e) begin
      k++;
      if (f) begin
        model_clear();
      end else begin
        m_ov = 1'b0;
        if (pq.size() > 0 && pq[0].due == k) begin
          p = pq.pop_front();
          c = ref_clamp(p.val);
          hist.push_back(c);
          if (hist.size() > 3) void'(hist.pop_front());
          m_last = (c != p.val);
          m_seen = m_seen | m_last;
          if (hist.size() == 3) m_out = ref_median(hist[0], hist[1], hist[2]);
          else m_out = c;
`ifdef MEDIAN_BYPASS_EN
          if (b) m_out = c;
`endif
          m_ov = 1'b1;
        end
        if (v) pq.push_back('{val: d, due: k + 2});
      end
    end
    #1;
    check("model_uo_out", uo_out, m_out);
    check("model_uio_out", uio_out, {m_last, m_seen, (pq.size() != 0), m_ov & e, 4'b0000});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_out;
    logic       exp_clamped;
  } vec_t;

  vec_t tbl[8];
  logic [7:0] med_exp[4];
  logic [7:0] med_in[4];

  initial begin
    tbl[0] = '{8'h05, 8'h10, 1'b1};
    tbl[1] = '{8'hFF, 8'hEF, 1'b1};
    tbl[2] = '{8'h10, 8'h10, 1'b0};
    tbl[3] = '{8'hEF, 8'hEF, 1'b0};
    tbl[4] = '{8'h0F, 8'h10, 1'b1};
    tbl[5] = '{8'hF0, 8'hEF, 1'b1};
    tbl[6] = '{8'h40, 8'h40, 1'b0};
    tbl[7] = '{8'h00, 8'h10, 1'b1};

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #12;
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'hF0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Latency of a single sample
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h40);
    check("lat_busy1", {7'd0, uio_out[5]}, 8'h01);
    idle(1);
    check("lat_busy2", {7'd0, uio_out[5]}, 8'h01);
    check("lat_noval", {7'd0, uio_out[4]}, 8'h00);
    idle(1);
    check("lat_out", uo_out, 8'h40);
    check("lat_status", uio_out, 8'h10);
    idle(2);
    check("lat_hold", uo_out, 8'h40);
    check("lat_quiet", uio_out, 8'h00);

    // Clamp table, one isolated sample per row after a flush
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 1'b0, 1'b0, tbl[i].din);
      idle(2);
      check($sformatf("tbl%0d_out", i), uo_out, tbl[i].exp_out);
      check($sformatf("tbl%0d_flags", i), {6'd0, uio_out[7:6]}, {6'd0, tbl[i].exp_clamped, tbl[i].exp_clamped});
      check($sformatf("tbl%0d_valid", i), {7'd0, uio_out[4]}, 8'h01);
    end

    // Median: ramp stream then spike stream, back-to-back
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin
        med_in  = '{8'h20, 8'h80, 8'h30, 8'h30};
        med_exp = '{8'h20, 8'h80, 8'h30, 8'h30};
      end else begin
        med_in  = '{8'h50, 8'h50, 8'hE0, 8'h50};
        med_exp = '{8'h50, 8'h50, 8'h50, 8'h50};
      end
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 6; i++) begin
        step(1'b1, (i < 4), 1'b0, 1'b0, (i < 4) ? med_in[i] : 8'h00);
        if (i >= 2) begin
          check($sformatf("med%0d_out%0d", s, i - 2), uo_out, med_exp[i - 2]);
          check($sformatf("med%0d_val%0d", s, i - 2), {7'd0, uio_out[4]}, 8'h01);
        end
      end
    end

    // Flush drops a simultaneous sample and empties the history
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h99);
    check("flush_uo_out", uo_out, 8'h00);
    check("flush_uio_out", uio_out, 8'h00);
    idle(3);
    check("flush_no99", uio_out, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h60);
    idle(2);
    check("flush_next", uo_out, 8'h60);

    // Stall with a sample in flight
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h70);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'hAA);
      check("stall_busy", {7'd0, uio_out[5]}, 8'h01);
      check("stall_noval", {7'd0, uio_out[4]}, 8'h00);
    end
    idle(1);
    check("stall_s2", {7'd0, uio_out[4]}, 8'h00);
    idle(1);
    check("stall_out", uo_out, 8'h70);
    check("stall_val", {7'd0, uio_out[4]}, 8'h01);

    // Random stream against the model, with a mid-run async reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check("rnd_reset_uo", uo_out, 8'h00);
        check("rnd_reset_uio", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
      end
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 3),
           1'($urandom), 8'($urandom));
    end
    check("final_uio_oe", uio_oe, 8'hF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
